picomips_seq_decoder: RTL and testbench



---
 rtl/picomips_dec_pkg.sv | 24 ++
 rtl/picomips_op_decode.sv | 54 +++++
 rtl/picomips_seq_decoder.sv | 144 ++++++++++++++
 tb/tb_picomips_seq_decoder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/picomips_dec_pkg.sv
// Shared opcode, ALU-code and FSM-state definitions for the picoMIPS sequencing decoder.
package picomips_dec_pkg;

  localparam int OP_NOP     = 0;
  localparam int OP_ADD     = 1;
  localparam int OP_ADDI    = 2;
  localparam int OP_MULI    = 3;
  localparam int OP_DIVIDED = 4;
  localparam int OP_LOAD1   = 5;
  localparam int OP_LOAD2   = 6;
  localparam int OP_STORE   = 7;
  localparam int OP_BLT     = 8;
  localparam int OP_SHOW    = 9;

  localparam logic [1:0] RNOP     = 2'd0;
  localparam logic [1:0] RADD     = 2'd1;
  localparam logic [1:0] RMUL     = 2'd2;
  localparam logic [1:0] RDIVIDED = 2'd3;

  typedef enum logic [2:0] {
    S_EXEC, S_MULTI, S_LDWAIT, S_SHOWH, S_TRAP
  } dec_state_t;

endpackage

// File: rtl/picomips_op_decode.sv
// Single-cycle opcode decode; also flags the opcodes that need the sequencer's attention.
module picomips_op_decode
  import picomips_dec_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           lt,
  output logic           pcincr,
  output logic           pcabsbranch,
  output logic [1:0]     alufunc,
  output logic           imm,
  output logic           w,
  output logic           sw,
  output logic           lw,
  output logic           show,
  output logic           is_mul,
  output logic           is_div,
  output logic           is_ld2,
  output logic           illegal
);

  always_comb begin
    pcincr      = 1'b1;
    pcabsbranch = 1'b0;
    alufunc     = RNOP;
    imm         = 1'b0;
    w           = 1'b0;
    sw          = 1'b0;
    lw          = 1'b0;
    show        = 1'b0;
    is_mul      = 1'b0;
    is_div      = 1'b0;
    is_ld2      = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPW'(OP_NOP):     ;
      OPW'(OP_ADD):     begin w = 1'b1; alufunc = RADD; end
      OPW'(OP_ADDI):    begin w = 1'b1; imm = 1'b1; alufunc = RADD; end
      OPW'(OP_MULI):    begin w = 1'b1; imm = 1'b1; alufunc = RMUL; is_mul = 1'b1; end
      OPW'(OP_DIVIDED): begin w = 1'b1; alufunc = RDIVIDED; is_div = 1'b1; end
      OPW'(OP_LOAD1):   begin imm = 1'b1; alufunc = RADD; end
      OPW'(OP_LOAD2):   begin lw = 1'b1; w = 1'b1; is_ld2 = 1'b1; end
      OPW'(OP_STORE):   begin sw = 1'b1; imm = 1'b1; alufunc = RADD; end
      OPW'(OP_BLT): begin
        imm = 1'b1;
        if (lt) begin pcincr = 1'b0; pcabsbranch = 1'b1; end
      end
      OPW'(OP_SHOW):    begin show = 1'b1; pcincr = 1'b0; end
      default:          begin pcincr = 1'b0; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/picomips_seq_decoder.sv
// Stateful picoMIPS decoder: stalls for multi-cycle MULI/DIVIDED and LOAD2,
// holds SHOW until a resume edge, and traps illegal opcodes until reset.
module picomips_seq_decoder
  import picomips_dec_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int MUL_CYC = 1,
  parameter int DIV_CYC = 1,
  parameter int LD_WAIT = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           LT,
  input  logic           resume,
  output logic           PCincr,
  output logic           PCabsbranch,
  output logic [1:0]     ALUfunc,
  output logic           imm,
  output logic           w,
  output logic           sw,
  output logic           lw,
  output logic           show,
  output logic           busy,
  output logic           err
);

  dec_state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [1:0] op_alu, op_alu_d;
  logic       op_imm, op_imm_d;
  logic       resume_q, err_d;

  logic       d_pcincr, d_pcabs, d_imm, d_w, d_sw, d_lw, d_show;
  logic       d_mul, d_div, d_ld2, d_illegal;
  logic [1:0] d_alu;

  picomips_op_decode #(.OPW(OPW)) u_dec (
    .opcode(opcode), .lt(LT),
    .pcincr(d_pcincr), .pcabsbranch(d_pcabs), .alufunc(d_alu), .imm(d_imm),
    .w(d_w), .sw(d_sw), .lw(d_lw), .show(d_show),
    .is_mul(d_mul), .is_div(d_div), .is_ld2(d_ld2), .illegal(d_illegal)
  );

  assign busy = (state != S_EXEC);

  always_comb begin
    PCincr      = 1'b1;
    PCabsbranch = 1'b0;
    ALUfunc     = RNOP;
    imm         = 1'b0;
    w           = 1'b0;
    sw          = 1'b0;
    lw          = 1'b0;
    show        = 1'b0;
    state_d     = state;
    cnt_d       = cnt;
    op_alu_d    = op_alu;
    op_imm_d    = op_imm;
    err_d       = err;
    case (state)
      S_EXEC: begin
        PCincr      = d_pcincr;
        PCabsbranch = d_pcabs;
        ALUfunc     = d_alu;
        imm         = d_imm;
        w           = d_w;
        sw          = d_sw;
        lw          = d_lw;
        show        = d_show;
        if (d_illegal) begin
          state_d = S_TRAP;
          err_d   = 1'b1;
        end else if (d_show) begin
          state_d = S_SHOWH;
        end else if ((d_mul && MUL_CYC > 1) || (d_div && DIV_CYC > 1)) begin
          // Counter holds the remaining stall cycles after this entry cycle
          PCincr   = 1'b0;
          w        = 1'b0;
          cnt_d    = d_mul ? 4'(MUL_CYC - 2) : 4'(DIV_CYC - 2);
          op_alu_d = d_alu;
          op_imm_d = d_imm;
          state_d  = S_MULTI;
        end else if (d_ld2 && LD_WAIT > 0) begin
          PCincr  = 1'b0;
          w       = 1'b0;
          cnt_d   = 4'(LD_WAIT - 1);
          state_d = S_LDWAIT;
        end
      end
      S_MULTI: begin
        ALUfunc = op_alu;
        imm     = op_imm;
        if (cnt != 4'd0) begin
          PCincr = 1'b0;
          cnt_d  = cnt - 4'd1;
        end else begin
          w       = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_LDWAIT: begin
        lw = 1'b1;
        if (cnt != 4'd0) begin
          PCincr = 1'b0;
          cnt_d  = cnt - 4'd1;
        end else begin
          w       = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_SHOWH: begin
        show   = 1'b1;
        PCincr = 1'b0;
        // A level already high on entry must drop and rise again to release
        if (resume && !resume_q) begin
          PCincr  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_TRAP:  PCincr = 1'b0;
      default: state_d = S_EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_EXEC;
      cnt      <= 4'd0;
      op_alu   <= RNOP;
      op_imm   <= 1'b0;
      resume_q <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      op_alu   <= op_alu_d;
      op_imm   <= op_imm_d;
      resume_q <= resume;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_picomips_seq_decoder.sv
// Directed bench: default-parameter instance for single-cycle decode, and a
// configured instance (MUL_CYC=4, DIV_CYC=6, LD_WAIT=2) for the sequencing paths.
module tb_picomips_seq_decoder;

  logic       clk = 1'b0;
  logic       reset, LT, resume;
  logic [3:0] opcode;

  logic       d_pci, d_pab, d_imm, d_w, d_sw, d_lw, d_show, d_busy, d_err;
  logic [1:0] d_alu;
  logic       c_pci, c_pab, c_imm, c_w, c_sw, c_lw, c_show, c_busy, c_err;
  logic [1:0] c_alu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picomips_seq_decoder u_def (
    .clk(clk), .reset(reset), .opcode(opcode), .LT(LT), .resume(resume),
    .PCincr(d_pci), .PCabsbranch(d_pab), .ALUfunc(d_alu), .imm(d_imm), .w(d_w),
    .sw(d_sw), .lw(d_lw), .show(d_show), .busy(d_busy), .err(d_err)
  );

  picomips_seq_decoder #(.OPW(4), .MUL_CYC(4), .DIV_CYC(6), .LD_WAIT(2)) u_cfg (
    .clk(clk), .reset(reset), .opcode(opcode), .LT(LT), .resume(resume),
    .PCincr(c_pci), .PCabsbranch(c_pab), .ALUfunc(c_alu), .imm(c_imm), .w(c_w),
    .sw(c_sw), .lw(c_lw), .show(c_show), .busy(c_busy), .err(c_err)
  );

  // {PCincr, PCabsbranch, ALUfunc[1:0], imm, w, sw, lw, show, busy, err}
  wire [10:0] ctl_d = {d_pci, d_pab, d_alu, d_imm, d_w, d_sw, d_lw, d_show, d_busy, d_err};
  wire [10:0] ctl_c = {c_pci, c_pab, c_alu, c_imm, c_w, c_sw, c_lw, c_show, c_busy, c_err};

  function automatic logic [10:0] ex(input logic pci, pab, input logic [1:0] alu,
                                     input logic im, wr, s, l, sh, bz, er);
    return {pci, pab, alu, im, wr, s, l, sh, bz, er};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then let the Mealy outputs settle before checking
  task automatic cyc(input logic [3:0] op, input logic lt, input logic rs, input logic rst);
    @(negedge clk);
    opcode = op; LT = lt; resume = rs; reset = rst;
    #1;
  endtask

  logic [10:0] dtab [9];
  logic [10:0] e;

  initial begin
    reset = 1'b1; opcode = '0; LT = 1'b0; resume = 1'b0;
    dtab[0] = ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    dtab[1] = ex(1, 0, 2'd1, 0, 1, 0, 0, 0, 0, 0);
    dtab[2] = ex(1, 0, 2'd1, 1, 1, 0, 0, 0, 0, 0);
    dtab[3] = ex(1, 0, 2'd2, 1, 1, 0, 0, 0, 0, 0);
    dtab[4] = ex(1, 0, 2'd3, 0, 1, 0, 0, 0, 0, 0);
    dtab[5] = ex(1, 0, 2'd1, 1, 0, 0, 0, 0, 0, 0);
    dtab[6] = ex(1, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0);
    dtab[7] = ex(1, 0, 2'd1, 1, 0, 1, 0, 0, 0, 0);
    dtab[8] = ex(1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0);

    cyc(4'd0, 0, 0, 1);
    cyc(4'd0, 0, 0, 1);
    cyc(4'd0, 0, 0, 0);
    chk("reset_def", ctl_d, dtab[0]);
    chk("reset_cfg", ctl_c, dtab[0]);

    // Single-cycle decode, both LT values
    for (int op = 0; op < 9; op++) begin
      for (int lt = 0; lt < 2; lt++) begin
        cyc(4'(op), 1'(lt), 0, 0);
        e = dtab[op];
        if (op == 8 && lt == 1) e = ex(0, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0);
        chk($sformatf("def_op%0d_lt%0d", op, lt), ctl_d, e);
      end
    end

    cyc(4'd0, 0, 0, 1);
    cyc(4'd0, 0, 0, 0);
    chk("cfg_idle", ctl_c, dtab[0]);

    // MULI over 4 cycles
    cyc(4'd3, 0, 0, 0); chk("mul_c1", ctl_c, ex(0, 0, 2'd2, 1, 0, 0, 0, 0, 0, 0));
    cyc(4'd3, 0, 0, 0); chk("mul_c2", ctl_c, ex(0, 0, 2'd2, 1, 0, 0, 0, 0, 1, 0));
    cyc(4'd3, 0, 0, 0); chk("mul_c3", ctl_c, ex(0, 0, 2'd2, 1, 0, 0, 0, 0, 1, 0));
    cyc(4'd3, 0, 0, 0); chk("mul_c4", ctl_c, ex(1, 0, 2'd2, 1, 1, 0, 0, 0, 1, 0));
    cyc(4'd0, 0, 0, 0); chk("mul_done", ctl_c, dtab[0]);

    // LOAD2 with two wait cycles
    cyc(4'd6, 0, 0, 0); chk("ld_c1", ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0));
    cyc(4'd6, 0, 0, 0); chk("ld_c2", ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 1, 0, 1, 0));
    cyc(4'd6, 0, 0, 0); chk("ld_c3", ctl_c, ex(1, 0, 2'd0, 0, 1, 0, 1, 0, 1, 0));
    cyc(4'd0, 0, 0, 0); chk("ld_done", ctl_c, dtab[0]);

    // SHOW entered with resume already high: needs a fresh edge
    cyc(4'd0, 0, 1, 0);
    cyc(4'd9, 0, 1, 0); chk("show_entry", ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 0, 1, 0);
      chk($sformatf("show_hold%0d", i), ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
    end
    cyc(4'd0, 0, 0, 0); chk("show_low", ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
    cyc(4'd0, 0, 1, 0); chk("show_release", ctl_c, ex(1, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
    cyc(4'd0, 0, 1, 0); chk("show_done", ctl_c, dtab[0]);

    // DIVIDED aborted by reset in its third cycle: no write ever
    cyc(4'd4, 0, 0, 0); chk("div_c1", ctl_c, ex(0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0));
    cyc(4'd4, 0, 0, 0); chk("div_c2", ctl_c, ex(0, 0, 2'd3, 0, 0, 0, 0, 0, 1, 0));
    cyc(4'd4, 0, 0, 1); chk("div_c3_rst", ctl_c, ex(0, 0, 2'd3, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      cyc(4'd0, 0, 0, 0);
      chk($sformatf("div_abort%0d", i), ctl_c, dtab[0]);
    end

    // Illegal opcode traps until reset
    cyc(4'hF, 0, 0, 0); chk("trap_entry", ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 11; i++) begin
      cyc(4'(i % 10), 1'(i % 2), 1'(i % 3 == 0), 0);
      chk($sformatf("trap_hold%0d", i), ctl_c, ex(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1));
    end
    cyc(4'd0, 0, 0, 1);
    cyc(4'd0, 0, 0, 0); chk("trap_reset", ctl_c, dtab[0]);
    cyc(4'd1, 0, 0, 0); chk("post_trap_add", ctl_c, dtab[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
